// File: rtl/sum_accum_29b.sv
// rtl/sum_accum_29b.sv - block accumulator for the pipelined adder sum stream
// Sums blk_len samples into a DW+LW-bit total and holds it until downstream accepts.
module sum_accum_29b #(
   parameter int DW = 29,
   parameter int LW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LW-1:0]    blk_len,
   input  logic [DW-1:0]    sum_in,
   input  logic             sum_valid,
   output logic             in_ready,
   output logic [DW+LW-1:0] acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      drop_cnt
);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    len_q, cnt_q, cnt_inc;
   logic [DW+LW-1:0] acc_q;
   logic [15:0]      drop_q;
   logic             load, take, last;

   // A latched length of 0 wraps the counter exactly at 2^LW samples.
   assign cnt_inc = cnt_q + LW'(1);
   assign last    = (cnt_inc == len_q);

   assign in_ready  = (state_q == ACC);
   assign take      = in_ready & sum_valid;
   assign out_valid = (state_q == DONE);
   assign acc_out   = acc_q;
   assign drop_cnt  = drop_q;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = ACC;
            end
         end
         ACC: begin
            if (sum_valid && last) state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               if (start) begin
                  load    = 1'b1;
                  state_d = ACC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            len_q <= blk_len;
            cnt_q <= '0;
            acc_q <= '0;
         end else if (take) begin
            cnt_q <= cnt_inc;
            acc_q <= acc_q + {{LW{1'b0}}, sum_in};
         end
         if (sum_valid && !in_ready && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_sum_accum_29b.sv
// tb/tb_sum_accum_29b.sv - self-checking bench for sum_accum_29b
// Directed table of blocks, hand-written corner sequences and random blocks vs. an arithmetic model.
module tb_sum_accum_29b;

   localparam int DW = 29;
   localparam int LW = 8;

   logic             clk = 1'b0;
   logic             rst, start, sum_valid, out_ready;
   logic [LW-1:0]    blk_len;
   logic [DW-1:0]    sum_in;
   logic             in_ready, out_valid;
   logic [DW+LW-1:0] acc_out;
   logic [15:0]      drop_cnt;

   int n_tests  = 0;
   int n_fail   = 0;
   int exp_drop = 0;

   typedef struct {
      int            n;
      logic [DW-1:0] val;
      int            gap;
      int            hold;
      logic [63:0]   exp;
   } vec_t;

   vec_t tbl [6];

   always #5 clk = ~clk;

   sum_accum_29b #(.DW(DW), .LW(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .blk_len   (blk_len),
      .sum_in    (sum_in),
      .sum_valid (sum_valid),
      .in_ready  (in_ready),
      .acc_out   (acc_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .drop_cnt  (drop_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int sat16(input int d);
      return (d > 65535) ? 65535 : d;
   endfunction

   task automatic begin_block(input int n);
      start   = 1'b1;
      blk_len = LW'(n);
      tick();
      start   = 1'b0;
      check("start_ready", {63'd0, in_ready}, 64'd1);
      check("start_no_valid", {63'd0, out_valid}, 64'd0);
   endtask

   task automatic feed(input int n, input int gap, input bit rnd, input logic [DW-1:0] fixed,
                       output longint unsigned total);
      logic [DW-1:0] v;
      total = 0;
      for (int i = 0; i < n; i++) begin
         repeat (gap) begin
            sum_valid = 1'b0;
            sum_in    = DW'($urandom);
            tick();
            check("stall_ready", {63'd0, in_ready}, 64'd1);
         end
         v         = rnd ? DW'($urandom) : fixed;
         sum_valid = 1'b1;
         sum_in    = v;
         total     = total + 64'(v);
         tick();
         sum_valid = 1'b0;
         if (i < n - 1) check("early_done", {63'd0, out_valid}, 64'd0);
      end
   endtask

   task automatic finish(input int hold, input logic [63:0] exp, input bit chain, input int next_n);
      check("done_valid", {63'd0, out_valid}, 64'd1);
      check("done_total", 64'(acc_out), exp);
      check("done_not_ready", {63'd0, in_ready}, 64'd0);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         sum_valid = 1'($urandom_range(0, 1));
         sum_in    = DW'($urandom);
         if (sum_valid) exp_drop++;
         tick();
         sum_valid = 1'b0;
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_total", 64'(acc_out), exp);
      end
      out_ready = 1'b1;
      if (chain) begin
         start   = 1'b1;
         blk_len = LW'(next_n);
      end
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      check("after_ack_valid", {63'd0, out_valid}, 64'd0);
      check("after_ack_ready", {63'd0, in_ready}, chain ? 64'd1 : 64'd0);
      check("drop_cnt", 64'(drop_cnt), 64'(sat16(exp_drop)));
   endtask

   initial begin
      logic [DW-1:0]   basic [4];
      longint unsigned tot, tot2;
      int              n, k;

      tbl[0] = '{n: 1,   val: 29'h5,        gap: 0, hold: 0, exp: 64'h5};
      tbl[1] = '{n: 2,   val: 29'h1FFFFFFF, gap: 0, hold: 1, exp: 64'h3FFFFFFE};
      tbl[2] = '{n: 3,   val: 29'h7,        gap: 2, hold: 5, exp: 64'h15};
      tbl[3] = '{n: 5,   val: 29'h100,      gap: 1, hold: 2, exp: 64'h500};
      tbl[4] = '{n: 256, val: 29'h1FFFFFFF, gap: 0, hold: 0, exp: 64'h1FFFFFFF00};
      tbl[5] = '{n: 255, val: 29'h1,        gap: 0, hold: 1, exp: 64'hFF};

      rst = 1'b1; start = 1'b0; blk_len = '0; sum_in = '0; sum_valid = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_ready", {63'd0, in_ready}, 64'd0);
      check("rst_acc", 64'(acc_out), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);

      // Samples before any start are refused and counted as drops.
      sum_valid = 1'b1;
      sum_in    = 29'h123;
      tick();
      tick();
      exp_drop += 2;
      sum_valid = 1'b0;
      check("idle_refuse", {63'd0, in_ready}, 64'd0);
      check("idle_acc", 64'(acc_out), 64'd0);

      // Basic back-to-back block with one-cycle latency.
      basic[0] = 29'h0000001; basic[1] = 29'h0000002; basic[2] = 29'h1FFFFFFF; basic[3] = 29'h0000010;
      begin_block(4);
      for (int i = 0; i < 4; i++) begin
         sum_valid = 1'b1;
         sum_in    = basic[i];
         tick();
         check("basic_valid", {63'd0, out_valid}, (i == 3) ? 64'd1 : 64'd0);
      end
      sum_valid = 1'b0;
      finish(0, 64'h20000012, 1'b0, 0);

      for (int t = 0; t < 6; t++) begin
         begin_block(tbl[t].n);
         feed(tbl[t].n, tbl[t].gap, 1'b0, tbl[t].val, tot);
         finish(tbl[t].hold, tbl[t].exp, 1'b0, 0);
      end

      // Restart straight out of DONE: only the two fresh samples count.
      begin_block(3);
      feed(3, 0, 1'b1, '0, tot);
      finish(1, 64'(tot), 1'b1, 2);
      feed(2, 0, 1'b1, '0, tot2);
      finish(0, 64'(tot2), 1'b0, 0);

      for (int r = 0; r < 30; r++) begin
         k = $urandom_range(0, 3);
         repeat (k) begin
            sum_valid = 1'($urandom_range(0, 1));
            sum_in    = DW'($urandom);
            if (sum_valid) exp_drop++;
            tick();
         end
         sum_valid = 1'b0;
         n = $urandom_range(1, 24);
         begin_block(n);
         feed(n, $urandom_range(0, 2), 1'b1, '0, tot);
         finish($urandom_range(0, 3), 64'(tot), 1'b0, 0);
      end

      // Reset in the middle of a block discards the partial sum.
      begin_block(4);
      feed(2, 0, 1'b1, '0, tot);
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      exp_drop = 0;
      check("midrst_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_ready", {63'd0, in_ready}, 64'd0);
      check("midrst_acc", 64'(acc_out), 64'd0);
      check("midrst_drop", 64'(drop_cnt), 64'd0);
      begin_block(4);
      feed(4, 0, 1'b1, '0, tot);
      finish(0, 64'(tot), 1'b0, 0);

      // Drop counter counts refused offers and saturates.
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      sum_valid = 1'b1;
      repeat (10) tick();
      check("drop_10", 64'(drop_cnt), 64'd10);
      repeat (65530) tick();
      check("drop_sat", 64'(drop_cnt), 64'hFFFF);
      repeat (3) tick();
      check("drop_hold", 64'(drop_cnt), 64'hFFFF);
      sum_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
